fetch_unit: RTL and testbench

Instruction-fetch stage of the KGPMini RISC processor. It owns the program counter, drives the word address into the combinational `instruction_memory`, and captures the returned word into an instruction register for the decode stage. It handles stalls, absolute jumps, PC-relative branches, and halt/resume. Redirects are applied with a one-slot squash.

---
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// KGPMini instruction-fetch stage: owns the PC, addresses instruction memory and
// registers the fetched word. Redirects squash one slot; halt freezes the PC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] NOP_WORD = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic        halt,
  input  logic        resume,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  output logic        halted
);

  localparam logic ST_RUN    = 1'b0;
  localparam logic ST_HALTED = 1'b1;

  logic        state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;

    if (state_q == ST_HALTED) begin
      // Resume only re-enters RUN; the frozen PC is fetched on the following edge.
      if (resume) begin
        state_d = ST_RUN;
      end
    end else if (halt) begin
      state_d    = ST_HALTED;
      ir_d       = NOP_WORD;
      ir_valid_d = 1'b0;
    end else if (jump_en) begin
      pc_d       = jump_target;
      ir_d       = NOP_WORD;
      ir_valid_d = 1'b0;
    end else if (branch_taken) begin
      pc_d       = ir_pc_q + branch_offset;
      ir_d       = NOP_WORD;
      ir_valid_d = 1'b0;
    end else if (!stall) begin
      ir_d       = imem_data;
      ir_pc_d    = pc_q;
      ir_valid_d = 1'b1;
      pc_d       = pc_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      ir_q       <= NOP_WORD;
      ir_pc_q    <= RESET_PC;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;
  assign halted    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; instruction memory returns 0x100 + address.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branch_taken, jump_en, halt, resume;
  logic [31:0] branch_offset, jump_target;
  logic [31:0] imem_addr, imem_data, ir, ir_pc;
  logic        ir_valid, halted;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.RESET_PC(32'd0), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump_en(jump_en), .jump_target(jump_target),
    .halt(halt), .resume(resume), .imem_addr(imem_addr), .imem_data(imem_data),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .halted(halted)
  );

  always #5 clk = ~clk;
  assign imem_data = 32'h100 + imem_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    stall = 0; branch_taken = 0; jump_en = 0; halt = 0; resume = 0;
    branch_offset = 0; jump_target = 0;
  endtask

  task automatic chk_ir(input string tag, input logic [31:0] e_ir, input logic [31:0] e_pc,
                        input logic e_v, input logic [31:0] e_addr);
    chk({tag, ".ir"}, ir, e_ir);
    chk({tag, ".ir_pc"}, ir_pc, e_pc);
    chk({tag, ".valid"}, {31'd0, ir_valid}, {31'd0, e_v});
    chk({tag, ".addr"}, imem_addr, e_addr);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #2;
    chk_ir("reset", NOP, 0, 0, 0);
    chk("reset.halted", {31'd0, halted}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Sequential fetch
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_ir($sformatf("run%0d", k), 32'h100 + k, k, 1, k + 1);
    end

    // Stall two cycles holding 0x102
    stall = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk_ir($sformatf("stall%0d", k), 32'h102, 2, 1, 3);
    end
    stall = 0;
    tick(); chk_ir("unstall", 32'h103, 3, 1, 4);
    tick(); tick(); chk_ir("run5", 32'h105, 5, 1, 6);

    // Backward branch from ir_pc=5 by -3
    branch_taken = 1; branch_offset = 32'hFFFF_FFFD;
    tick(); idle(); chk_ir("br_bubble", NOP, 5, 0, 2);
    tick(); chk_ir("br_target", 32'h102, 2, 1, 3);

    // Get ir_pc=0, then branch -1 wraps to 0xFFFFFFFF
    jump_en = 1; jump_target = 0;
    tick(); idle(); chk_ir("j0_bubble", NOP, 2, 0, 0);
    tick(); chk_ir("j0_target", 32'h100, 0, 1, 1);
    branch_taken = 1; branch_offset = 32'hFFFF_FFFF;
    tick(); idle(); chk("brwrap.addr", imem_addr, 32'hFFFF_FFFF);
    tick(); chk_ir("pcwrap", 32'h0000_00FF, 32'hFFFF_FFFF, 1, 0);

    // Jump beats branch
    jump_en = 1; jump_target = 32'h40; branch_taken = 1; branch_offset = 32'd5;
    tick(); idle(); chk_ir("jmp_vs_br", NOP, 32'hFFFF_FFFF, 0, 32'h40);

    // Redirect beats stall
    jump_en = 1; jump_target = 32'h20; stall = 1;
    tick(); idle(); chk_ir("jmp_vs_stall", NOP, 32'hFFFF_FFFF, 0, 32'h20);
    tick(); chk_ir("jmp20_target", 32'h120, 32'h20, 1, 32'h21);

    // Halt at PC=7 (resume in same cycle loses in RUN)
    jump_en = 1; jump_target = 7;
    tick(); idle();
    halt = 1; resume = 1;
    tick(); idle();
    chk("halt.halted", {31'd0, halted}, 1);
    chk_ir("halt", NOP, 32'h20, 0, 7);
    jump_en = 1; jump_target = 32'h30; branch_taken = 1; branch_offset = 32'd4;
    tick(); idle();
    chk("halted_jmp.halted", {31'd0, halted}, 1);
    chk_ir("halted_jmp", NOP, 32'h20, 0, 7);
    resume = 1; halt = 1;
    tick(); idle();
    chk("resume.halted", {31'd0, halted}, 0);
    chk_ir("resume", NOP, 32'h20, 0, 7);
    tick(); chk_ir("post_resume", 32'h107, 7, 1, 8);
    tick(); chk_ir("run8", 32'h108, 8, 1, 9);

    // Asynchronous reset mid-run with a pending jump
    jump_en = 1; jump_target = 32'h55; stall = 1;
    #2 rst = 1'b1;
    #1;
    chk_ir("async_rst", NOP, 0, 0, 0);
    chk("async_rst.halted", {31'd0, halted}, 0);
    @(negedge clk);
    idle();
    rst = 1'b0;
    tick(); chk_ir("restart", 32'h100, 0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
